// File: rtl/lcd_spi_write.sv
// lcd_spi_write: serial write engine for a 4-wire SPI LCD (ST7789-class).
// Takes one 9-bit word (bit 8 = DC, bits 7:0 = payload) from the init/draw
// controller, shifts it out MSB first in SPI mode 0, and pulses wr_done for
// one cycle once the word has left the pins.
//
// Parameters:
//   HALF_PERIOD  SCK half-period in sys_clk_50MHz cycles (>= 1, default 2).
//
// Ports:
//   sys_clk_50MHz  in   system clock, rising-edge logic
//   sys_rst_n      in   synchronous active-low reset
//   en_write       in   level, high while the controller has words to send
//   data[8:0]      in   {DC, payload}
//   wr_done        out  one-cycle pulse per completed word
//   lcd_cs         out  chip select, active low
//   lcd_dc         out  data/command select
//   lcd_sck        out  SPI clock, idle low
//   lcd_mosi       out  serial data
//
// Optional feature macro: LCD_WR_CS_KEEP_EN
//   Defined:   CS stays low between words while en_write is held high, and
//              rises one cycle after the first IDLE/DONE cycle with en_write low.
//   Undefined: CS is released after every word.

module lcd_spi_write #(
    parameter int HALF_PERIOD = 2
) (
    input  logic       sys_clk_50MHz,
    input  logic       sys_rst_n,
    input  logic       en_write,
    input  logic [8:0] data,
    output logic       wr_done,
    output logic       lcd_cs,
    output logic       lcd_dc,
    output logic       lcd_sck,
    output logic       lcd_mosi
);

    localparam int              HP_W    = $clog2(HALF_PERIOD + 1);
    localparam logic [HP_W-1:0] HP_LAST = HP_W'(HALF_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, DONE} state_t;

    state_t          state,   state_nxt;
    logic [1:0]      arm_cnt, arm_cnt_nxt;
    logic [2:0]      bit_cnt, bit_cnt_nxt;
    logic [HP_W-1:0] hp_cnt,  hp_cnt_nxt;
    logic            sck_hi,  sck_hi_nxt;
    // bit 8 holds DC for the whole frame; bit 7 is the bit on MOSI
    logic [8:0]      shreg,   shreg_nxt;
    logic            hp_last;

`ifdef LCD_WR_CS_KEEP_EN
    // set while a CS burst spans several words
    logic            burst,   burst_nxt;
`endif

    assign hp_last = (hp_cnt == HP_LAST);

    always_ff @(posedge sys_clk_50MHz) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            arm_cnt <= '0;
            bit_cnt <= '0;
            hp_cnt  <= '0;
            sck_hi  <= 1'b0;
            shreg   <= '0;
`ifdef LCD_WR_CS_KEEP_EN
            burst   <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            arm_cnt <= arm_cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            hp_cnt  <= hp_cnt_nxt;
            sck_hi  <= sck_hi_nxt;
            shreg   <= shreg_nxt;
`ifdef LCD_WR_CS_KEEP_EN
            burst   <= burst_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        arm_cnt_nxt = arm_cnt;
        bit_cnt_nxt = bit_cnt;
        hp_cnt_nxt  = hp_cnt;
        sck_hi_nxt  = sck_hi;
        shreg_nxt   = shreg;
`ifdef LCD_WR_CS_KEEP_EN
        burst_nxt   = burst;
`endif
        wr_done     = 1'b0;
        lcd_cs      = 1'b1;
        lcd_dc      = 1'b0;
        lcd_sck     = 1'b0;
        lcd_mosi    = 1'b0;

        case (state)
            IDLE: begin
`ifdef LCD_WR_CS_KEEP_EN
                lcd_cs = ~burst;
                if (!en_write) burst_nxt = 1'b0;
`endif
                if (en_write) begin
                    // Second consecutive high cycle: controller data is valid now.
                    if (arm_cnt == 2'd1) begin
                        shreg_nxt   = data;
                        arm_cnt_nxt = '0;
                        bit_cnt_nxt = '0;
                        hp_cnt_nxt  = '0;
                        sck_hi_nxt  = 1'b0;
                        state_nxt   = SHIFT;
`ifdef LCD_WR_CS_KEEP_EN
                        burst_nxt   = 1'b1;
`endif
                    end else begin
                        arm_cnt_nxt = arm_cnt + 2'd1;
                    end
                end else begin
                    arm_cnt_nxt = '0;
                end
            end

            SHIFT: begin
                lcd_cs   = 1'b0;
                lcd_dc   = shreg[8];
                lcd_mosi = shreg[7];
                lcd_sck  = sck_hi;
                if (hp_last) begin
                    hp_cnt_nxt = '0;
                    if (!sck_hi) begin
                        sck_hi_nxt = 1'b1;
                    end else begin
                        // high->low: present the next bit, or finish after bit 0
                        sck_hi_nxt = 1'b0;
                        if (bit_cnt == 3'd7) begin
                            state_nxt = HOLD;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 3'd1;
                            shreg_nxt   = {shreg[8], shreg[6:0], 1'b0};
                        end
                    end
                end else begin
                    hp_cnt_nxt = hp_cnt + 1'b1;
                end
            end

            HOLD: begin
                lcd_cs   = 1'b0;
                lcd_dc   = shreg[8];
                lcd_mosi = shreg[7];
                if (hp_last) begin
                    hp_cnt_nxt = '0;
                    state_nxt  = DONE;
                end else begin
                    hp_cnt_nxt = hp_cnt + 1'b1;
                end
            end

            DONE: begin
                wr_done     = 1'b1;
`ifdef LCD_WR_CS_KEEP_EN
                lcd_cs      = ~burst;
                if (!en_write) burst_nxt = 1'b0;
`endif
                arm_cnt_nxt = '0;
                bit_cnt_nxt = '0;
                state_nxt   = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lcd_spi_write.sv
// Bench for lcd_spi_write. Drives words with a model of the init controller,
// queues the expected byte/DC and wr_done cycle for each word, and decodes the
// SPI pins in a separate monitor that compares against the queue.
// A second instance with HALF_PERIOD = 1 checks the fast-clock latency and CS
// framing (burst or per-word depending on LCD_WR_CS_KEEP_EN).

module tb_lcd_spi_write;

    localparam int HP = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic [8:0] data  = '0;
    logic       wr_done, cs, dc, sck, mosi;

    logic       en2   = 1'b0;
    logic [8:0] data2 = '0;
    logic       wr_done2, cs2, dc2, sck2, mosi2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [8:0] w;
        int         done;
    } exp_t;

    exp_t exp_q[$];
    bit   mon_hold = 1'b1;

    lcd_spi_write #(.HALF_PERIOD(HP)) dut (
        .sys_clk_50MHz(clk), .sys_rst_n(rst_n), .en_write(en), .data(data),
        .wr_done(wr_done), .lcd_cs(cs), .lcd_dc(dc), .lcd_sck(sck), .lcd_mosi(mosi)
    );

    lcd_spi_write #(.HALF_PERIOD(1)) dut2 (
        .sys_clk_50MHz(clk), .sys_rst_n(rst_n), .en_write(en2), .data(data2),
        .wr_done(wr_done2), .lcd_cs(cs2), .lcd_dc(dc2), .lcd_sck(sck2), .lcd_mosi(mosi2)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // A word latched at cycle l must finish 1 + 17*HP cycles later.
    function automatic void expect_word(input logic [8:0] w, input int l);
        exp_t e;
        e.w    = w;
        e.done = l + 1 + 17 * HP;
        exp_q.push_back(e);
    endfunction

    // Monitor: decode SCK rising edges, check framing, compare on wr_done.
    initial begin : monitor
        logic       rise;
        logic       win;
        logic       sck_prev;
        logic [7:0] acc;
        int         nb;
        exp_t       e;
        sck_prev = 1'b0;
        acc      = '0;
        nb       = 0;
        forever begin
            @(negedge clk);
            rise     = sck && !sck_prev;
            sck_prev = sck;
            if (mon_hold) begin
                nb = 0;
            end else begin
                win = (exp_q.size() > 0) && (cyc >= exp_q[0].done - 17 * HP) && (cyc < exp_q[0].done);
                if (win) begin
                    chk("cs_frame", cs, 1'b0);
                    chk("dc_frame", dc, exp_q[0].w[8]);
                end else begin
                    chk("sck_idle", sck, 1'b0);
`ifndef LCD_WR_CS_KEEP_EN
                    chk("cs_idle", cs, 1'b1);
`endif
                end
                if (rise) begin
                    acc = {acc[6:0], mosi};
                    nb++;
                end
                if (wr_done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_cycle", cyc, e.done);
                        chk("bit_count", nb, 8);
                        chk("byte", acc, e.w[7:0]);
                    end
                    nb = 0;
                end
            end
        end
    end

    task automatic wait_done(output int d);
        d = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wr_done) begin
                d = cyc;
                return;
            end
        end
        chk("done_timeout", 0, 1);
    endtask

    // One isolated word; en_write rises one cycle before data is valid.
    task automatic send_word(input logic [8:0] w, input bit drop);
        int d;
        @(posedge clk); #1 en = 1'b1; data = 9'($urandom);
        @(posedge clk); #1 data = w; expect_word(w, cyc);
        @(posedge clk); #1 data = 9'($urandom);
        if (drop) begin
            repeat (8) @(posedge clk);
            #1 en = 1'b0;
        end
        wait_done(d);
        @(posedge clk); #1 en = 1'b0;
    endtask

    // Init-controller model: next word appears two cycles after wr_done.
    task automatic run_seq();
        logic [8:0] seq [14];
        int d;
        int dprev;
        foreach (seq[i]) seq[i] = 9'($urandom);
        dprev = 0;
        @(posedge clk); #1 en = 1'b1; data = 9'($urandom);
        @(posedge clk); #1 data = seq[0]; expect_word(seq[0], cyc);
        for (int k = 0; k < 14; k++) begin
            wait_done(d);
            if (d < 0) break;
            if (k > 0) chk("word_spacing", d - dprev, 17 * HP + 3);
            dprev = d;
            @(posedge clk); #1;
            if (k == 13) begin
                en = 1'b0;
            end else begin
                @(posedge clk); #1 data = seq[k + 1]; expect_word(seq[k + 1], cyc);
            end
        end
        en = 1'b0;
    endtask

    task automatic reset_mid_word(input logic [8:0] w);
        int l;
        @(posedge clk); #1 en = 1'b1; data = 9'($urandom);
        @(posedge clk); #1 data = w; l = cyc; expect_word(w, l);
        // fourth bit spans SHIFT offsets 6*HP .. 8*HP-1
        while (cyc < l + 1 + 6 * HP + 1) begin
            @(posedge clk); #1;
        end
        mon_hold = 1'b1;
        rst_n    = 1'b0;
        en       = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_cs",   cs,      1'b1);
        chk("rst_mid_sck",  sck,     1'b0);
        chk("rst_mid_mosi", mosi,    1'b0);
        chk("rst_mid_dc",   dc,      1'b0);
        chk("rst_mid_done", wr_done, 1'b0);
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1; mon_hold = 1'b0;
        repeat (40) @(posedge clk);
        #1;
    endtask

    task automatic dut2_test();
        logic [8:0] w [3];
        int         l [3];
        int         d [3];
        int         e0;
        int         n2;
        int         k2;
        logic [7:0] a2;
        logic       p2;
        logic       exp_cs;
        logic       exp_dn;
        for (int k = 0; k < 3; k++) w[k] = 9'($urandom);
        e0   = cyc + 1;
        l[0] = e0 + 1;   d[0] = l[0] + 18;
        l[1] = d[0] + 2; d[1] = l[1] + 18;
        l[2] = d[1] + 2; d[2] = l[2] + 18;
        n2 = 0; k2 = 0; a2 = '0; p2 = sck2;
        for (int c = e0; c <= d[2] + 5; c++) begin
            @(posedge clk); #1;
            en2   = (c <= d[2]);
            data2 = (c >= l[2]) ? w[2] : (c >= l[1]) ? w[1] : (c >= l[0]) ? w[0] : 9'($urandom);
            @(negedge clk);
            exp_dn = (c == d[0]) || (c == d[1]) || (c == d[2]);
            chk("hp1_done", wr_done2, exp_dn);
`ifdef LCD_WR_CS_KEEP_EN
            exp_cs = !((c >= l[0] + 1) && (c <= d[2] + 1));
`else
            exp_cs = 1'b1;
            for (int k = 0; k < 3; k++)
                if ((c >= l[k] + 1) && (c < d[k])) exp_cs = 1'b0;
`endif
            chk("hp1_cs", cs2, exp_cs);
            if (sck2 && !p2) begin
                a2 = {a2[6:0], mosi2};
                n2++;
                chk("hp1_dc", dc2, w[k2][8]);
            end
            p2 = sck2;
            if (wr_done2) begin
                chk("hp1_byte", a2, w[k2][7:0]);
                chk("hp1_bits", n2, 8);
                n2 = 0;
                if (k2 < 2) k2++;
            end
        end
        en2 = 1'b0;
    endtask

    initial begin : watchdog
        #(20 * 100000);
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs",   cs,      1'b1);
        chk("rst_sck",  sck,     1'b0);
        chk("rst_mosi", mosi,    1'b0);
        chk("rst_dc",   dc,      1'b0);
        chk("rst_done", wr_done, 1'b0);
        chk("rst_cs2",  cs2,     1'b1);
        @(posedge clk); #1 rst_n = 1'b1; mon_hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        send_word(9'h011, 1'b0);
        send_word(9'h1A0, 1'b0);
        for (int i = 0; i < 4; i++) send_word(9'($urandom), 1'b0);

        // single-cycle en_write must not arm a transfer
        @(posedge clk); #1 en = 1'b1; data = 9'($urandom);
        @(posedge clk); #1 en = 1'b0;
        repeat (50) @(posedge clk);
        #1;

        send_word(9'($urandom), 1'b1);
        run_seq();
        reset_mid_word(9'($urandom));
        send_word(9'($urandom), 1'b0);
        dut2_test();

        repeat (5) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
